// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: the never-execute
// default word, FSM state encoding and the latency counter width.
package imem_pkg;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'hF000_0000;
    localparam int          CNT_W            = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/imem_ram.sv
// Program storage: 2**ADDR_W x 32 words, synchronous write, asynchronous read.
// A read in the same cycle as a write to that address sees the old word.
module imem_ram #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Memory end of the fetch interface: accepts word-addressed requests, returns
// the instruction exactly LATENCY cycles later, and drops fetches on flush.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          ADDR_W   = 6,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    input  logic              flush,
    output logic              busy,
    output logic              resp_valid,
    output logic [31:0]       resp_instr,
    output logic [31:0]       resp_addr,
    output logic              resp_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);

    localparam logic [32:0]      DEPTH_33 = 33'(1) << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_lat_addr;
    logic [31:0]      r_lat_instr;
    logic             r_lat_err;
    logic [31:0]      r_out_addr;
    logic [31:0]      r_out_instr;
    logic             r_out_err;

    logic             w_ready;
    logic             w_accept;
    logic             w_err;
    logic [31:0]      w_rdata;
    logic [31:0]      w_instr;

    imem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (load_en),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (req_addr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    // Full 32-bit range check so aliased high addresses are never served.
    assign w_err    = ({1'b0, req_addr} >= DEPTH_33);
    assign w_instr  = w_err ? NOP_WORD : w_rdata;

    assign w_ready  = ((r_state == IDLE) || (r_state == RESP)) && !flush;
    assign w_accept = w_ready && req_valid;
    assign busy     = !w_ready;

    assign resp_valid = (r_state == RESP) && !flush;
    assign resp_instr = r_out_instr;
    assign resp_addr  = r_out_addr;
    assign resp_err   = r_out_err;

    // Latch registers capture at accept; output registers change only when a
    // response is presented, so the previous response stays visible meanwhile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_lat_addr  <= '0;
            r_lat_instr <= NOP_WORD;
            r_lat_err   <= 1'b0;
            r_out_addr  <= '0;
            r_out_instr <= NOP_WORD;
            r_out_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lat_addr  <= req_addr;
                r_lat_instr <= w_instr;
                r_lat_err   <= w_err;
            end

            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_out_addr  <= req_addr;
                            r_out_instr <= w_instr;
                            r_out_err   <= w_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (r_cnt == '0) begin
                        r_state     <= RESP;
                        r_out_addr  <= r_lat_addr;
                        r_out_instr <= r_lat_instr;
                        r_out_err   <= r_lat_err;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (ADDR_W=6, LATENCY=2): inputs driven just
// after the rising edge, outputs sampled on the falling edge.
module tb_imem_responder;

    localparam int          ADDR_W  = 6;
    localparam int          LATENCY = 2;
    localparam logic [31:0] NOP     = 32'hF000_0000;

    localparam logic [31:0] W0   = 32'h1000_0000;
    localparam logic [31:0] W1   = 32'h1000_0001;
    localparam logic [31:0] W2   = 32'h1000_0002;
    localparam logic [31:0] W3   = 32'hE3A0_0014;
    localparam logic [31:0] W5   = 32'h5555_0005;
    localparam logic [31:0] W7   = 32'h7777_0007;
    localparam logic [31:0] W7N1 = 32'hA7A7_0001;
    localparam logic [31:0] W7N2 = 32'hB7B7_0002;
    localparam logic [31:0] W20  = 32'h2020_2020;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [31:0]       req_addr;
    logic              flush;
    logic              busy;
    logic              resp_valid;
    logic [31:0]       resp_instr;
    logic [31:0]       resp_addr;
    logic              resp_err;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imem_responder #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .flush      (flush),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_instr (resp_instr),
        .resp_addr  (resp_addr),
        .resp_err   (resp_err),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        next_cycle();
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        next_cycle();
        load_en   = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] a,
                               input logic [31:0] ins, input logic err);
        check_val({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check_val({tag, ".instr"}, resp_instr, ins);
        check_val({tag, ".addr"},  resp_addr,  a);
        check_val({tag, ".err"},   32'(resp_err), 32'(err));
        $display("resp %-8s addr=%0d instr=%h err=%0b", tag, resp_addr, resp_instr, resp_err);
    endtask

    task automatic expect_quiet(input string tag, input logic exp_busy);
        check_val({tag, ".valid"}, 32'(resp_valid), 32'd0);
        check_val({tag, ".busy"},  32'(busy),       32'(exp_busy));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        // Reset state.
        repeat (2) next_cycle();
        rst = 1'b1;
        sample();
        expect_quiet("rst", 1'b0);
        check_val("rst.instr", resp_instr, NOP);
        check_val("rst.addr",  resp_addr,  32'd0);
        check_val("rst.err",   32'(resp_err), 32'd0);

        load_word(6'd0, W0);
        load_word(6'd1, W1);
        load_word(6'd2, W2);
        load_word(6'd3, W3);
        load_word(6'd5, W5);
        load_word(6'd7, W7);
        load_word(6'd20, W20);

        // Single fetch, addr 3.
        next_cycle(); req_valid = 1'b1; req_addr = 32'd3;
        sample();     expect_quiet("f3.acc", 1'b0);
        next_cycle(); req_valid = 1'b0;
        sample();     expect_quiet("f3.wait", 1'b1);
        next_cycle();
        sample();     expect_resp("f3", 32'd3, W3, 1'b0);
                      check_val("f3.busy", 32'(busy), 32'd0);
        next_cycle();
        sample();     expect_quiet("f3.after", 1'b0);
                      check_val("f3.hold", resp_instr, W3);

        // Back-to-back fetches 0,1,2.
        for (int i = 0; i < 3; i++) begin
            next_cycle(); req_valid = 1'b1; req_addr = 32'(i);
            sample();
            check_val("b2b.busy", 32'(busy), 32'd0);
            if (i == 0) check_val("b2b.valid0", 32'(resp_valid), 32'd0);
            if (i == 1) expect_resp("b2b0", 32'd0, W0, 1'b0);
            if (i == 2) expect_resp("b2b1", 32'd1, W1, 1'b0);
            next_cycle(); req_valid = 1'b0;
            sample();     expect_quiet("b2b.wait", 1'b1);
        end
        next_cycle();
        sample();     expect_resp("b2b2", 32'd2, W2, 1'b0);
        next_cycle();
        sample();     expect_quiet("b2b.idle", 1'b0);

        // Flush in WAIT, then new fetch at 20 (flush+req ignored first).
        next_cycle(); req_valid = 1'b1; req_addr = 32'd5;
        sample();
        next_cycle(); flush = 1'b1; req_addr = 32'd9;
        sample();     expect_quiet("fl.wait", 1'b1);
        next_cycle(); flush = 1'b0; req_addr = 32'd20;
        sample();     expect_quiet("fl.idle", 1'b0);
                      check_val("fl.hold", resp_addr, 32'd2);
        next_cycle(); req_valid = 1'b0;
        sample();     expect_quiet("fl.w20", 1'b1);
        next_cycle();
        sample();     expect_resp("f20", 32'd20, W20, 1'b0);

        // Flush during RESP masks the response and blocks the accept.
        next_cycle(); req_valid = 1'b1; req_addr = 32'd3;
        sample();
        next_cycle(); req_valid = 1'b0;
        sample();
        next_cycle(); flush = 1'b1; req_valid = 1'b1; req_addr = 32'd1;
        sample();     expect_quiet("flr.resp", 1'b1);
        next_cycle(); flush = 1'b0; req_valid = 1'b0;
        sample();     expect_quiet("flr.idle", 1'b0);
        next_cycle();
        sample();     expect_quiet("flr.none", 1'b0);

        // Out-of-range fetches.
        next_cycle(); req_valid = 1'b1; req_addr = 32'd64;
        sample();
        next_cycle(); req_valid = 1'b0;
        sample();
        next_cycle();
        sample();     expect_resp("oor64", 32'd64, NOP, 1'b1);
        next_cycle(); req_valid = 1'b1; req_addr = 32'h8000_0003;
        sample();
        next_cycle(); req_valid = 1'b0;
        sample();
        next_cycle();
        sample();     expect_resp("oorhi", 32'h8000_0003, NOP, 1'b1);
        next_cycle(); req_valid = 1'b1; req_addr = 32'd63;
        sample();
        next_cycle(); req_valid = 1'b0;
        sample();
        next_cycle();
        sample();     check_val("edge63.err", 32'(resp_err), 32'd0);

        // Load collision at addr 7: accept-cycle and WAIT-cycle writes.
        next_cycle(); req_valid = 1'b1; req_addr = 32'd7;
                      load_en = 1'b1; load_addr = 6'd7; load_data = W7N1;
        sample();
        next_cycle(); req_valid = 1'b0; load_data = W7N2;
        sample();
        next_cycle(); load_en = 1'b0;
        sample();     expect_resp("coll7", 32'd7, W7, 1'b0);
        next_cycle(); req_valid = 1'b1; req_addr = 32'd7;
        sample();
        next_cycle(); req_valid = 1'b0;
        sample();
        next_cycle();
        sample();     expect_resp("new7", 32'd7, W7N2, 1'b0);

        // Reset asserted during WAIT.
        next_cycle(); req_valid = 1'b1; req_addr = 32'd1;
        sample();
        next_cycle(); req_valid = 1'b0; rst = 1'b0;
        sample();     expect_quiet("rw.rst", 1'b0);
                      check_val("rw.instr", resp_instr, NOP);
                      check_val("rw.addr",  resp_addr,  32'd0);
        next_cycle(); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            expect_quiet("rw.post", 1'b0);
            next_cycle();
        end
        sample();
        check_val("rw.instr2", resp_instr, NOP);
        check_val("rw.err",    32'(resp_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
